alu_md_ctrl_unit: RTL
=====================

# alu_md_ctrl_unit

Parametrised successor to the combinational ALU control decode. It generates the `ALUSelection` code for base RV32I ALU operations and adds an iterative RV32M multiply/divide sequencer with a pipeline-stall handshake. It sits in the EX stage beside the ALU. For M-extension instructions it raises `stall` until its own result is ready, and the EX result mux selects `md_result` while `md_sel` is high.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; must be ≥4 and even.
- `CNT_W`, $clog2(XLEN)+1: iteration counter width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ALUOp` input 3: operation class from the main control unit.
- `F3` input 3: instruction funct3.
- `F7` input 7: instruction funct7.
- `start` input 1: EX instruction valid; held high by the pipeline while stalled.
- `flush` input 1: synchronous abort of any M operation in flight.
- `op_a` input XLEN: rs1 value.
- `op_b` input XLEN: rs2 value.
- `ALUSelection` output 4: ALU function code (combinational).
- `md_sel` output 1: the current instruction is an M-extension operation (combinational).
- `stall` output 1: hold the pipeline (combinational).
- `busy` output 1: sequencer in RUN or DONE (registered).
- `done` output 1: one-cycle result-valid pulse (registered).
- `md_result` output XLEN: M-operation result (registered).

## Operation
- **M-op detection:** `md_sel` = (`ALUOp`==`ALU_OP_Arith`) && (`F7`==`F7_MULDIV`).
- **ALUSelection decode:**
  - Load → `ALU_ADD`; PASS → `ALU_PASS`.
  - Arith_I: ADD/OR/XOR/AND/SLL/SRL/SLT/SLTU by F3.
  - Arith: same as Arith_I, except F3=ADD with F7[5]=1 gives `ALU_SUB`.
  - Unlisted combinations and every M op → `ALU_PASS`.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on `start && md_sel && !flush`. On this edge the block latches F3, the operand magnitudes and the sign flags, and clears the counter.
  - IDLE → DONE directly, through the special-case path:
    - divide by zero: quotient = all ones; remainder = dividend.
    - signed overflow (DIV/REM with a = MIN, b = −1): quotient = MIN; remainder = 0.
  - RUN executes one iteration per cycle: shift-add multiply or restoring divide on the magnitudes. After XLEN iterations it goes to DONE, and the sign-corrected result is written to `md_result` on that edge.
  - DONE → IDLE unconditionally, after one cycle.
- **Sign rules:**
  - MUL, MULH, DIV and REM are signed×signed.
  - MULHSU treats `op_a` as signed and `op_b` as unsigned.
  - MULHU, DIVU and REMU are unsigned.
  - Product sign is sa^sb, applied to the full 2·XLEN product.
  - Quotient sign is sa^sb. Remainder sign follows the dividend.
  - MUL returns product[XLEN-1:0]; the MULH variants return product[2XLEN-1:XLEN].
- **Handshake:**
  - `stall` = `md_sel && start && !done`.
  - The pipeline advances in the cycle where `done`=1. `start` is ignored outside IDLE.
  - The pipeline must present a new instruction, or drop `start`, in the cycle after `done`. A start seen in IDLE always begins a new operation.
- **flush and rst:** either one, in any state, forces IDLE on the next edge. `done` stays 0, there is no `md_result` update, and `flush` has priority over `start`.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `md_result` 0, counter 0.
- Normal M op, with start accepted at edge 0:
  - RUN occupies cycles 1..XLEN.
  - `done`=1 and `md_result` is valid in cycle XLEN+1, which is cycle 33 at XLEN=32.
- Special-case divide: `done` in cycle 1.
- `md_result` holds its value until the next completed operation.
- `busy` is high in RUN and DONE only.
- Non-M ops have zero latency. `stall` and `busy` stay 0 for them.
- Counter reaching terminal count and `flush` in the same cycle: the flush wins and there is no `done`.

## Structure
- `defines.v` gains:
  - `F7_MULDIV` (7'b0000001).
  - F3 codes: `F3_MUL`, `F3_MULH`, `F3_MULHSU`, `F3_MULHU`, `F3_DIV`, `F3_DIVU`, `F3_REM`, `F3_REMU`.
  - State encodings: `MD_IDLE`, `MD_RUN`, `MD_DONE`.
- Existing `ALU_*` and `ALU_OP_*` macros are reused unchanged.
- One sub-module, `md_iter_core`: holds the per-cycle shift-add/restoring datapath and the accumulator, quotient and remainder registers. The FSM, decode and sign fixup stay in the top.

## Test plan
- **Non-M decode:** ALUOp=Arith, F3=ADD, F7=0x20 → `ALUSelection`=`ALU_SUB`, `md_sel`=0, `stall`=0, `busy` stays 0.
- **MUL:** a=7, b=0xFFFFFFFD → `done` in cycle 33, `md_result`=0xFFFFFFEB, `stall` high in cycles 0..32.
- **MULHU:** a=b=0xFFFFFFFF → `md_result`=0xFFFFFFFE. MULH with the same operands → 0x00000000.
- **Divide special cases:**
  - DIVU 5/0 → `done` in cycle 1, result 0xFFFFFFFF.
  - REM −7/0 → 0xFFFFFFF9.
  - DIV 0x80000000/−1 → 0x80000000.
  - REM 0x80000000/−1 → 0.
- **Signed divide:** DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. Both with `done` in cycle 33.
- **Abort:** assert `flush` in cycle 10 of a DIV → `busy`=0 in cycle 11, no `done` pulse, `md_result` unchanged. Repeat with `rst` for the same behaviour.

Source files
------------

// File: rtl/alu_md_ctrl_unit_pkg.sv
// Shared encodings for the ALU control decode and the RV32M multiply/divide sequencer.
package alu_md_ctrl_unit_pkg;

  localparam logic [2:0] ALU_OP_Load    = 3'b000;
  localparam logic [2:0] ALU_OP_Arith_I = 3'b001;
  localparam logic [2:0] ALU_OP_Arith   = 3'b010;
  localparam logic [2:0] ALU_OP_PASS    = 3'b011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_PASS = 4'd9;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_RUN  = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  typedef struct packed {
    logic [2:0] f3;
    logic       neg_q;
    logic       neg_r;
  } md_op_t;

  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SRL:  return ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic md_signed_a(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  function automatic logic md_signed_b(input logic [2:0] f3);
    return md_signed_a(f3) && (f3 != F3_MULHSU);
  endfunction

endpackage

// File: rtl/alu_md_ctrl_unit_if.sv
// EX-stage bundle between the pipeline and the ALU control / M-extension unit.
interface alu_md_ctrl_unit_if #(
  parameter int XLEN = 32
);
  logic [2:0]      ALUOp;
  logic [2:0]      F3;
  logic [6:0]      F7;
  logic            start;
  logic            flush;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [3:0]      ALUSelection;
  logic            md_sel;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] md_result;

  modport master (
    output ALUOp, F3, F7, start, flush, op_a, op_b,
    input  ALUSelection, md_sel, stall, busy, done, md_result
  );

  modport slave (
    input  ALUOp, F3, F7, start, flush, op_a, op_b,
    output ALUSelection, md_sel, stall, busy, done, md_result
  );
endinterface

// File: rtl/alu_md_ctrl_unit_md_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide on unsigned magnitudes.
module md_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] divisor;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Next-state values are exported so the final step can be folded into the result write.
  always_comb begin
    sum      = {1'b0, acc} + (quo[0] ? {1'b0, divisor} : '0);
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, divisor};
    acc_next = acc;
    quo_next = quo;
    rem_next = rem;
    if (is_div) begin
      rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_next = sum[XLEN:1];
      quo_next = {sum[0], quo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
    end else if (load) begin
      acc     <= '0;
      quo     <= a_mag;
      rem     <= '0;
      divisor <= b_mag;
    end else if (step) begin
      acc <= acc_next;
      quo <= quo_next;
      rem <= rem_next;
    end
  end
endmodule

// File: rtl/alu_md_ctrl_unit.sv
// ALU function decode for RV32I plus the RV32M sequencer FSM, special cases and sign fixup.
module alu_md_ctrl_unit
  import alu_md_ctrl_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic               clk,
  input logic               rst,
  alu_md_ctrl_unit_if.slave bus
);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  md_op_t            op_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [3:0]        sel;
  logic              md_sel;
  logic              accept;
  logic              last_iter;
  logic              sign_a;
  logic              sign_b;
  logic              spec_zero;
  logic              spec_ovf;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   special;
  logic [XLEN-1:0]   acc_next;
  logic [XLEN-1:0]   quo_next;
  logic [XLEN-1:0]   rem_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_result;

  assign md_sel    = (bus.ALUOp == ALU_OP_Arith) && (bus.F7 == F7_MULDIV);
  assign accept    = (state == MD_IDLE) && bus.start && md_sel && !bus.flush;
  assign last_iter = (state == MD_RUN) && (cnt == CNT_W'(XLEN - 1));

  always_comb begin
    sel = ALU_PASS;
    case (bus.ALUOp)
      ALU_OP_Load:    sel = ALU_ADD;
      ALU_OP_Arith_I: sel = f3_to_alu(bus.F3);
      ALU_OP_Arith: begin
        if (md_sel)
          sel = ALU_PASS;
        else if ((bus.F3 == F3_ADD) && bus.F7[5])
          sel = ALU_SUB;
        else
          sel = f3_to_alu(bus.F3);
      end
      default:        sel = ALU_PASS;
    endcase
  end

  // Divide-by-zero and MIN/-1 bypass the iterative core entirely.
  always_comb begin
    sign_a    = md_signed_a(bus.F3) && bus.op_a[XLEN-1];
    sign_b    = md_signed_b(bus.F3) && bus.op_b[XLEN-1];
    mag_a     = sign_a ? -bus.op_a : bus.op_a;
    mag_b     = sign_b ? -bus.op_b : bus.op_b;
    spec_zero = bus.F3[2] && (bus.op_b == '0);
    spec_ovf  = bus.F3[2] && !bus.F3[0] && (bus.op_a == XMIN) && (bus.op_b == '1);
    if (spec_zero)
      special = bus.F3[1] ? bus.op_a : '1;
    else
      special = bus.F3[1] ? '0 : XMIN;
  end

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (state == MD_RUN),
    .is_div   (op_q.f3[2]),
    .a_mag    (mag_a),
    .b_mag    (mag_b),
    .acc_next (acc_next),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  always_comb begin
    prod_fix = op_q.neg_q ? -{acc_next, quo_next} : {acc_next, quo_next};
    quo_fix  = op_q.neg_q ? -quo_next : quo_next;
    rem_fix  = op_q.neg_r ? -rem_next : rem_next;
    case (op_q.f3)
      F3_MUL:                        final_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  final_result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               final_result = quo_fix;
      default:                       final_result = rem_fix;
    endcase
  end

  // Flush outranks everything except reset, including a terminal-count completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      state  <= MD_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            busy_q <= 1'b1;
            if (spec_zero || spec_ovf) begin
              state    <= MD_DONE;
              done_q   <= 1'b1;
              result_q <= special;
            end else begin
              state      <= MD_RUN;
              cnt        <= '0;
              op_q.f3    <= bus.F3;
              op_q.neg_q <= sign_a ^ sign_b;
              op_q.neg_r <= sign_a;
            end
          end
        end
        MD_RUN: begin
          if (last_iter) begin
            state    <= MD_DONE;
            done_q   <= 1'b1;
            result_q <= final_result;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= MD_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ALUSelection = sel;
  assign bus.md_sel       = md_sel;
  assign bus.stall        = md_sel && bus.start && !done_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.md_result    = result_q;
endmodule
